// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour move readout: one-hot move codes,
// compass headings, command opcodes and the command sequencer state encoding.
package tour_pkg;

   typedef enum logic [7:0] {
      MV_N2W1 = 8'h01,
      MV_N2E1 = 8'h02,
      MV_W2N1 = 8'h04,
      MV_W2S1 = 8'h08,
      MV_S2W1 = 8'h10,
      MV_S2E1 = 8'h20,
      MV_E2S1 = 8'h40,
      MV_E2N1 = 8'h80
   } encoded_move_t;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [3:0] OP_MOVE         = 4'b0010;
   localparam logic [3:0] OP_MOVE_FANFARE = 4'b0011;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LEG1_ISSUE,
      LEG1_WAIT,
      LEG2_ISSUE,
      LEG2_WAIT
   } tour_state_t;

   function automatic logic [15:0] makeCmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] squares);
      return {op, hdg, squares};
   endfunction

endpackage

// File: rtl/tour_move_decode.sv
// Combinational split of a one-hot knight move into its 2-square and 1-square
// leg headings; valid_onehot_o is low for zero or multiple bits set.
module tour_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move_i,
   output logic [7:0] leg1_hdg_o,
   output logic [7:0] leg2_hdg_o,
   output logic       valid_onehot_o
);

   always_comb begin
      leg1_hdg_o     = HDG_N;
      leg2_hdg_o     = HDG_N;
      valid_onehot_o = 1'b1;
      case (move_i)
         MV_N2W1: begin leg1_hdg_o = HDG_N; leg2_hdg_o = HDG_W; end
         MV_N2E1: begin leg1_hdg_o = HDG_N; leg2_hdg_o = HDG_E; end
         MV_W2N1: begin leg1_hdg_o = HDG_W; leg2_hdg_o = HDG_N; end
         MV_W2S1: begin leg1_hdg_o = HDG_W; leg2_hdg_o = HDG_S; end
         MV_S2W1: begin leg1_hdg_o = HDG_S; leg2_hdg_o = HDG_W; end
         MV_S2E1: begin leg1_hdg_o = HDG_S; leg2_hdg_o = HDG_E; end
         MV_E2S1: begin leg1_hdg_o = HDG_E; leg2_hdg_o = HDG_S; end
         MV_E2N1: begin leg1_hdg_o = HDG_E; leg2_hdg_o = HDG_N; end
         default: valid_onehot_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/tour_cmd.sv
// Walks the solver's move list after start_tour and issues two motion commands per move.
// Build option: define TOUR_FANFARE_EN to tag every second-leg command with MOVE_FANFARE.
module tour_cmd
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24,
   parameter int IDX_W     = 5
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_tour,
   input  logic [7:0]       move,
   output logic [IDX_W-1:0] indx,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic             tour_done,
   output logic             err
);

`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] LEG2_OP = OP_MOVE_FANFARE;
`else
   localparam logic [3:0] LEG2_OP = OP_MOVE;
`endif

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

   tour_state_t      state_q, state_d;
   logic [IDX_W-1:0] indx_q, indx_d;
   logic [15:0]      cmd_q, cmd_d;
   logic             rdy_q, rdy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [7:0]       move_q, move_d;

   logic [7:0]       decodeMove;
   logic [7:0]       leg1Hdg;
   logic [7:0]       leg2Hdg;
   logic             moveValid;

   // The live solver output is decoded during FETCH; later legs use the latched copy.
   assign decodeMove = (state_q == FETCH) ? move : move_q;

   tour_move_decode u_decode (
      .move_i         (decodeMove),
      .leg1_hdg_o     (leg1Hdg),
      .leg2_hdg_o     (leg2Hdg),
      .valid_onehot_o (moveValid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         indx_q  <= '0;
         cmd_q   <= 16'h0000;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         move_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         indx_q  <= indx_d;
         cmd_q   <= cmd_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         move_q  <= move_d;
      end
   end

   always_comb begin
      state_d = state_q;
      indx_d  = indx_q;
      cmd_d   = cmd_q;
      rdy_d   = rdy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      move_d  = move_q;
      case (state_q)
         IDLE: begin
            if (start_tour) begin
               indx_d  = '0;
               err_d   = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            move_d = move;
            if (!moveValid) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cmd_d   = makeCmd(OP_MOVE, leg1Hdg, 4'd2);
               rdy_d   = 1'b1;
               state_d = LEG1_ISSUE;
            end
         end
         LEG1_ISSUE: begin
            if (clr_cmd_rdy) begin
               rdy_d   = 1'b0;
               state_d = LEG1_WAIT;
            end
         end
         LEG1_WAIT: begin
            if (send_resp) begin
               cmd_d   = makeCmd(LEG2_OP, leg2Hdg, 4'd1);
               rdy_d   = 1'b1;
               state_d = LEG2_ISSUE;
            end
         end
         LEG2_ISSUE: begin
            if (clr_cmd_rdy) begin
               rdy_d   = 1'b0;
               state_d = LEG2_WAIT;
            end
         end
         LEG2_WAIT: begin
            // The last move holds indx at its final value rather than wrapping.
            if (send_resp) begin
               if (indx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  indx_d  = indx_q + IDX_W'(1);
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign indx      = indx_q;
   assign cmd       = cmd_q;
   assign cmd_rdy   = rdy_q;
   assign tour_done = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: stimulus pushes expected {indx, cmd} pairs, a negedge
// monitor pops one on every rising cmd_rdy. Honors TOUR_FANFARE_EN for second-leg opcodes.
module tb_tour_cmd;

`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] L2OP = 4'h3;
`else
   localparam logic [3:0] L2OP = 4'h2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  indx;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic        tour_done;
   logic        err;

   logic [7:0]  moveMem [0:31];
   logic [20:0] expQ [$];
   logic [20:0] expItem;
   logic        prevRdy = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int          doneCount = 0;
   int          doneBefore;

   tour_cmd #(.NUM_MOVES(24), .IDX_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_tour  (start_tour),
      .move        (move),
      .indx        (indx),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .send_resp   (send_resp),
      .tour_done   (tour_done),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Behaves like the solver's combinational move lookup.
   assign move = moveMem[indx];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prevRdy = 1'b0;
      end else begin
         if (cmd_rdy && !prevRdy) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected cmd: got %h, expected no command", cmd);
            end else begin
               expItem = expQ.pop_front();
               checkOutput("cmd word", 32'(cmd), 32'(expItem[15:0]));
               checkOutput("cmd indx", 32'(indx), 32'(expItem[20:16]));
            end
         end
         if (tour_done) doneCount++;
         prevRdy = cmd_rdy;
      end
   end

   task automatic pushExp(input logic [4:0] idx, input logic [15:0] c);
      expQ.push_back({idx, c});
   endtask

   task automatic applyStimulus();
      @(posedge clk); #1 start_tour = 1'b1;
      @(posedge clk); #1 start_tour = 1'b0;
   endtask

   task automatic waitRdy(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (cmd_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("[TB] FAIL cmd_rdy timeout: got 0, expected 1");
      end
   endtask

   task automatic serveCmd(input bit doResp);
      bit ok;
      waitRdy(ok);
      if (ok) begin
         clr_cmd_rdy = 1'b1;
         @(posedge clk); #1 clr_cmd_rdy = 1'b0;
         if (doResp) begin
            @(posedge clk); #1 send_resp = 1'b1;
            @(posedge clk); #1 send_resp = 1'b0;
         end
      end
   endtask

   initial begin
      bit ok;
      rst = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      for (int i = 0; i < 32; i++) moveMem[i] = 8'h40;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset indx", 32'(indx), 32'h0);
      checkOutput("reset cmd", 32'(cmd), 32'h0);
      checkOutput("reset cmd_rdy", 32'(cmd_rdy), 32'h0);
      checkOutput("reset tour_done", 32'(tour_done), 32'h0);
      checkOutput("reset err", 32'(err), 32'h0);
      rst = 1'b0;

      // Basic N2W1 move, then abandon the next move with a reset in LEG1_WAIT.
      moveMem[0] = 8'h01;
      moveMem[1] = 8'h01;
      pushExp(5'd0, 16'h2002);
      pushExp(5'd0, {L2OP, 12'h3F1});
      pushExp(5'd1, 16'h2002);
      applyStimulus();
      checkOutput("latency rdy low", 32'(cmd_rdy), 32'h0);
      @(posedge clk); #1;
      checkOutput("latency rdy high", 32'(cmd_rdy), 32'h1);
      serveCmd(1'b1);
      serveCmd(1'b1);
      serveCmd(1'b0);
      #3 rst = 1'b1;
      #1;
      checkOutput("midreset indx", 32'(indx), 32'h0);
      checkOutput("midreset cmd", 32'(cmd), 32'h0);
      checkOutput("midreset cmd_rdy", 32'(cmd_rdy), 32'h0);
      checkOutput("midreset err", 32'(err), 32'h0);
      checkOutput("midreset tour_done", 32'(tour_done), 32'h0);
      expQ.delete();
      @(posedge clk); #1 rst = 1'b0;

      // Full 24-move tour of E2S1 moves.
      for (int i = 0; i < 32; i++) moveMem[i] = 8'h40;
      for (int i = 0; i < 24; i++) begin
         pushExp(5'(i), 16'h2BF2);
         pushExp(5'(i), {L2OP, 12'h7F1});
      end
      doneBefore = doneCount;
      applyStimulus();
      checkOutput("restart indx", 32'(indx), 32'h0);
      for (int i = 0; i < 48; i++) serveCmd(1'b1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("tour_done pulses", 32'(doneCount - doneBefore), 32'h1);
      checkOutput("final indx", 32'(indx), 32'd23);
      checkOutput("idle cmd_rdy", 32'(cmd_rdy), 32'h0);
      checkOutput("tour queue empty", 32'(expQ.size()), 32'h0);

      // Mixed moves with handshake edge cases, back-pressure and a bad encoding at indx 5.
      moveMem[0] = 8'h01; moveMem[1] = 8'h02; moveMem[2] = 8'h04;
      moveMem[3] = 8'h08; moveMem[4] = 8'h10; moveMem[5] = 8'h00;
      pushExp(5'd0, 16'h2002); pushExp(5'd0, {L2OP, 12'h3F1});
      pushExp(5'd1, 16'h2002); pushExp(5'd1, {L2OP, 12'hBF1});
      pushExp(5'd2, 16'h23F2); pushExp(5'd2, {L2OP, 12'h001});
      pushExp(5'd3, 16'h23F2); pushExp(5'd3, {L2OP, 12'h7F1});
      pushExp(5'd4, 16'h27F2); pushExp(5'd4, {L2OP, 12'h3F1});
      doneBefore = doneCount;
      applyStimulus();
      repeat (4) serveCmd(1'b1);
      waitRdy(ok);
      clr_cmd_rdy = 1'b1; send_resp = 1'b1;
      @(posedge clk); #1 clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("early resp ignored", 32'(cmd_rdy), 32'h0);
      applyStimulus();
      @(posedge clk); #1;
      checkOutput("start ignored indx", 32'(indx), 32'd2);
      checkOutput("start ignored rdy", 32'(cmd_rdy), 32'h0);
      send_resp = 1'b1;
      @(posedge clk); #1 send_resp = 1'b0;
      serveCmd(1'b1);
      waitRdy(ok);
      for (int i = 0; i < 5; i++) begin
         repeat (20) @(posedge clk);
         #1;
         checkOutput("backpressure cmd", 32'(cmd), 32'h23F2);
         checkOutput("backpressure rdy", 32'(cmd_rdy), 32'h1);
         checkOutput("backpressure indx", 32'(indx), 32'd3);
      end
      repeat (4) serveCmd(1'b1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bad 00 err", 32'(err), 32'h1);
      checkOutput("bad 00 cmd_rdy", 32'(cmd_rdy), 32'h0);
      checkOutput("bad 00 indx", 32'(indx), 32'd5);
      checkOutput("bad 00 no done", 32'(doneCount - doneBefore), 32'h0);
      checkOutput("bad 00 queue empty", 32'(expQ.size()), 32'h0);

      moveMem[0] = 8'h03;
      applyStimulus();
      checkOutput("start clears err", 32'(err), 32'h0);
      @(posedge clk); #1;
      checkOutput("bad 03 err", 32'(err), 32'h1);
      checkOutput("bad 03 cmd_rdy", 32'(cmd_rdy), 32'h0);
      checkOutput("bad 03 indx", 32'(indx), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bad 03 no done", 32'(doneCount - doneBefore), 32'h0);

      moveMem[0] = 8'h20;
      pushExp(5'd0, 16'h27F2);
      applyStimulus();
      checkOutput("recover err clear", 32'(err), 32'h0);
      serveCmd(1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      checkOutput("final queue empty", 32'(expQ.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
